snoopy_bus_arbiter: RTL and testbench
=====================================

# snoopy_bus_arbiter

Shares one memory port among `NREQ` snoopy read-only caches, such as the I-cache and the D-cache. It serialises their read-refill and write-through requests. After every completed write it broadcasts an invalidation to every cache, so that no cache keeps a stale line. The block sits between the caches' SystemBus user ports and the memory controller.

## Interface
Parameters:
- `NREQ`, 2: number of requesters; requester index 0 is the lowest.
- `ADDR_WIDTH`, 32: address width.
- `WIDTH`, 128: data width.
- `MASKW`, `$clog2(WIDTH/8)`: write-mask width, matching the SystemBus `w_mask`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  NREQ  per-requester `rw_valid`
- `req_ready`  out  NREQ  per-requester `rw_ready`; one-cycle completion pulse
- `req_addr`  in  NREQ*ADDR_WIDTH  flattened `rw_addr`; requester i occupies `[i*ADDR_WIDTH +: ADDR_WIDTH]`
- `req_we`  in  NREQ  per-requester `rw_we`
- `req_ce`  in  NREQ  per-requester `w_ce`
- `req_mask`  in  NREQ*MASKW  flattened `w_mask`
- `req_wdata`  in  NREQ*WIDTH  flattened `w_data`
- `req_rdata`  out  WIDTH  `r_data`, broadcast to all requesters
- `inv_valid`  out  NREQ  per-cache invalidate request
- `inv_addr`  out  ADDR_WIDTH  invalidate address, shared by all caches
- `inv_ready`  in  NREQ  per-cache invalidate acknowledge
- `mem_valid`  out  1  memory request
- `mem_ready`  in  1  memory completion; `mem_rdata` is valid in this cycle
- `mem_addr`, `mem_we`, `mem_ce`, `mem_mask`, `mem_wdata`  out  ADDR_WIDTH/1/1/MASKW/WIDTH  latched request fields
- `mem_rdata`  in  WIDTH  read data

## Operation
- FSM states: `IDLE`, `ISSUE`, `RESP`.
- **IDLE:**
  - Compute the eligible set: `req_valid & ~(req_we & {NREQ{inv_pend != 0}})`.
  - Writes are held back while any invalidation is outstanding; reads are not.
  - If the eligible set is non-empty, pick winner `g`.
  - Latch `g` and its addr/we/ce/mask/wdata, then go to `ISSUE`.
- **ISSUE:**
  - `mem_valid=1`, with the memory fields driven from the latches.
  - On `mem_ready`: latch `mem_rdata` (reads only), then go to `RESP`.
- **RESP:**
  - `req_ready[g]=1` for one cycle; `req_rdata` = the latched data.
  - If the transaction was a write: `inv_pend <= {NREQ{1'b1}}` and `inv_addr <= latched addr`.
  - The writer is included in the invalidation set, because writes never update its own cache line.
  - Next state: `IDLE`.
- **Invalidation engine:** runs independently of the FSM.
  - `inv_valid = inv_pend`.
  - `inv_pend[i]` is cleared in the cycle after `inv_ready[i]` is sampled high.
  - `inv_addr` holds stable while `inv_pend != 0`.
  - Because reads keep being granted while invalidations are pending, a cache that is stalled in refill can finish its refill and then acknowledge. This breaks the refill/invalidate deadlock.
- **Simultaneous events:**
  - `inv_ready` for a bit that is not pending is ignored.
  - A new write cannot enter `RESP` while `inv_pend != 0`. The set and clear paths of `inv_pend` therefore never collide.
- **Reset values:**
  - State `IDLE`.
  - `req_ready=0`, `mem_valid=0`, `inv_valid=0`, `inv_addr=0`, `req_rdata=0`.
  - All latches and the round-robin pointer `rr_ptr` are 0.
- **Reset mid-operation:**
  - All state is dropped and `mem_valid` falls in the next cycle.
  - Pending invalidations are discarded; the caches are reset together with the arbiter.

## Timing
- Minimum request latency, counting from the cycle in which `req_valid` is sampled in `IDLE`:
  - cycle+1: `mem_valid` asserted.
  - If `mem_ready` arrives in the same cycle, `req_ready` is asserted at cycle+2.
  - Total: 2 cycles plus memory wait cycles.
- Requesters hold `req_valid` and all request fields stable until `req_ready`.
- The arbiter ignores `req_valid[g]` while it is in `ISSUE`/`RESP`.
- Back-to-back transactions: after `RESP`, `IDLE` arbitrates in the following cycle, so there is a one-cycle bubble.
- Invalidation latency: `inv_valid` rises in the cycle after `RESP` and stays high until acknowledged.

## Configuration
- `ARB_RR_EN` defined:
  - Round-robin arbitration: search starts at `rr_ptr` and wraps modulo `NREQ`.
  - `rr_ptr <= g+1` (wrapping) on entry to `ISSUE`.
- `ARB_RR_EN` undefined: fixed priority, lowest index wins; `rr_ptr` is absent.

## Structure
- Package `snoopy_bus_pkg` holds the `arb_stat_t` enum (`IDLE`/`ISSUE`/`RESP`) and the state reset constant.
- Sub-module `rr_pick`: combinational; inputs eligible mask and `rr_ptr`; outputs one-hot grant plus index.
  - With `ARB_RR_EN` undefined, it is instantiated with the pointer tied to 0.

## Test plan
- Single read from requester 0 at `0x1000`, `mem_ready` on the first `ISSUE` cycle, `mem_rdata=0xA5..A5` -> `req_ready[0]` at cycle+2 with `req_rdata=0xA5..A5`; `inv_valid` stays 0.
- Write from requester 1 at `0x2040`, mask `0xF` -> memory write observed; `req_ready[1]`; then `inv_valid=2'b11` with `inv_addr=0x2040`. Acknowledge cache 0, then cache 1 -> each bit clears in the cycle after its acknowledge.
- Write from requester 0 pending invalidation, with a new write from 1 and a read from 0 both requesting -> the read is granted and the write is stalled until `inv_pend==0`.
- Deadlock case: cache 0 refill waits while `inv_pend[0]` is set -> the refill completes and cache 0 then acknowledges; no hang within 50 cycles.
- Both requesters continuously reading, with `ARB_RR_EN` -> grants alternate 0,1,0,1; without `ARB_RR_EN` -> requester 0 always wins.
- `rst` asserted in `ISSUE` with `inv_pend=2'b01` -> the next cycle shows `mem_valid=0`, `inv_valid=0`, `req_ready=0`, state `IDLE`.

Source files
------------

// File: rtl/snoopy_bus_pkg.sv
// rtl/snoopy_bus_pkg.sv - shared types for the snoopy bus arbiter
package snoopy_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_stat_t;

  localparam arb_stat_t ARB_STAT_RST = IDLE;

endpackage

// File: rtl/snoopy_bus_arbiter_rr_pick.sv
// rtl/snoopy_bus_arbiter_rr_pick.sv - picks the first eligible requester at or after ptr_i, wrapping
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] elig_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o
);

  int j;

  // Walk from the far end back towards ptr_i so the nearest eligible slot is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr_i) + k) % NREQ;
      if (elig_i[IW'(j)]) begin
        gnt_o         = '0;
        gnt_o[IW'(j)] = 1'b1;
        idx_o         = IW'(j);
      end
    end
  end

endmodule

// File: rtl/snoopy_bus_arbiter.sv
// rtl/snoopy_bus_arbiter.sv - serialises cache refills/write-throughs onto one memory port and
// broadcasts invalidations after writes; define ARB_RR_EN for round-robin, else fixed priority.
module snoopy_bus_arbiter
  import snoopy_bus_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int WIDTH      = 128,
  parameter int MASKW      = $clog2(WIDTH/8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0]             req_ce,
  input  logic [NREQ*MASKW-1:0]       req_mask,
  input  logic [NREQ*WIDTH-1:0]       req_wdata,
  output logic [WIDTH-1:0]            req_rdata,
  output logic [NREQ-1:0]             inv_valid,
  output logic [ADDR_WIDTH-1:0]       inv_addr,
  input  logic [NREQ-1:0]             inv_ready,
  output logic                        mem_valid,
  input  logic                        mem_ready,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic                        mem_we,
  output logic                        mem_ce,
  output logic [MASKW-1:0]            mem_mask,
  output logic [WIDTH-1:0]            mem_wdata,
  input  logic [WIDTH-1:0]            mem_rdata
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_stat_t             state_q;
  logic [NREQ-1:0]       gnt_q, req_ready_q, inv_pend_q;
  logic [ADDR_WIDTH-1:0] addr_q, inv_addr_q;
  logic                  we_q, ce_q, mem_valid_q;
  logic [MASKW-1:0]      mask_q;
  logic [WIDTH-1:0]      wdata_q, rdata_q;

  logic [NREQ-1:0]       elig, pick_gnt;
  logic [IW-1:0]         pick_idx, rr_ptr;

  // Reads stay eligible during pending invalidations so a stalled refill can drain.
  assign elig = req_valid & ~(req_we & {NREQ{|inv_pend_q}});

`ifdef ARB_RR_EN
  logic [IW-1:0] rr_ptr_q;
  assign rr_ptr = rr_ptr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == IDLE && |elig) begin
      rr_ptr_q <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`else
  assign rr_ptr = '0;
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .elig_i (elig),
    .ptr_i  (rr_ptr),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_STAT_RST;
      gnt_q       <= '0;
      req_ready_q <= '0;
      inv_pend_q  <= '0;
      addr_q      <= '0;
      inv_addr_q  <= '0;
      we_q        <= 1'b0;
      ce_q        <= 1'b0;
      mem_valid_q <= 1'b0;
      mask_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
    end else begin
      req_ready_q <= '0;
      inv_pend_q  <= inv_pend_q & ~inv_ready;
      case (state_q)
        IDLE: begin
          if (|elig) begin
            gnt_q       <= pick_gnt;
            addr_q      <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            we_q        <= req_we[pick_idx];
            ce_q        <= req_ce[pick_idx];
            mask_q      <= req_mask[pick_idx*MASKW +: MASKW];
            wdata_q     <= req_wdata[pick_idx*WIDTH +: WIDTH];
            mem_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            if (!we_q) rdata_q <= mem_rdata;
            mem_valid_q <= 1'b0;
            req_ready_q <= gnt_q;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // Writer is invalidated too: write-through never refreshes its own line.
          if (we_q) begin
            inv_pend_q <= '1;
            inv_addr_q <= addr_q;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign req_rdata = rdata_q;
  assign inv_valid = inv_pend_q;
  assign inv_addr  = inv_addr_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_ce    = ce_q;
  assign mem_mask  = mask_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_snoopy_bus_arbiter.sv
// tb/tb_snoopy_bus_arbiter.sv - directed vector table, corner sequences and random traffic vs a transaction model
module tb_snoopy_bus_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int W    = 128;
  localparam int MW   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_we, req_ce, inv_valid, inv_ready;
  logic [63:0]   req_addr;
  logic [7:0]    req_mask;
  logic [255:0]  req_wdata;
  logic [127:0]  req_rdata, mem_rdata, mem_wdata;
  logic [31:0]   inv_addr, mem_addr;
  logic          mem_valid, mem_ready, mem_we, mem_ce;
  logic [3:0]    mem_mask;

  int n_cmp = 0;
  int n_bad = 0;

  snoopy_bus_arbiter #(.NREQ(NREQ), .ADDR_WIDTH(AW), .WIDTH(W), .MASKW(MW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_we(req_we),
    .req_ce(req_ce), .req_mask(req_mask), .req_wdata(req_wdata), .req_rdata(req_rdata),
    .inv_valid(inv_valid), .inv_addr(inv_addr), .inv_ready(inv_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_ce(mem_ce), .mem_mask(mem_mask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level reference: phase 0 waiting, 1 memory access, 2 completion pulse.
  int          m_ph, m_win, m_rr;
  logic [31:0] m_addr, m_iaddr;
  logic        m_we, m_ce;
  logic [3:0]  m_mask;
  logic [127:0] m_wdata, m_rdat;
  logic [1:0]  m_pend;

  function automatic int pick(input logic [1:0] ok, input int start);
    for (int k = 0; k < NREQ; k++)
      if (ok[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic predict();
    logic [1:0] ok, np;
    int w;
    if (rst) begin
      m_ph = 0; m_win = 0; m_rr = 0; m_addr = 0; m_iaddr = 0; m_we = 0; m_ce = 0;
      m_mask = 0; m_wdata = 0; m_rdat = 0; m_pend = 0;
      return;
    end
    np = m_pend & ~inv_ready;
    if (m_ph == 2 && m_we) begin
      np = 2'b11;
      m_iaddr = m_addr;
    end
    if (m_ph == 0) begin
      for (int i = 0; i < NREQ; i++)
        ok[i] = req_valid[i] && (!req_we[i] || m_pend == 2'b00);
      w = pick(ok, m_rr);
      if (w >= 0) begin
        m_win = w; m_addr = req_addr[w*32 +: 32]; m_we = req_we[w]; m_ce = req_ce[w];
        m_mask = req_mask[w*4 +: 4]; m_wdata = req_wdata[w*128 +: 128];
`ifdef ARB_RR_EN
        m_rr = (w + 1) % NREQ;
`endif
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      if (mem_ready) begin
        if (!m_we) m_rdat = mem_rdata;
        m_ph = 2;
      end
    end else begin
      m_ph = 0;
    end
    m_pend = np;
  endtask

  task automatic check_model();
    cmp("mdl_mem_valid", mem_valid, m_ph == 1);
    cmp("mdl_req_ready", req_ready, (m_ph == 2) ? (2'b01 << m_win) : 2'b00);
    cmp("mdl_inv_valid", inv_valid, m_pend);
    cmp("mdl_inv_addr", inv_addr, m_iaddr);
    cmp("mdl_req_rdata", req_rdata, m_rdat);
    if (m_ph == 1) begin
      cmp("mdl_mem_addr", mem_addr, m_addr);
      cmp("mdl_mem_we", mem_we, m_we);
      cmp("mdl_mem_ce", mem_ce, m_ce);
      cmp("mdl_mem_mask", mem_mask, m_mask);
      cmp("mdl_mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  task automatic tick();
    predict();
    @(negedge clk);
    check_model();
  endtask

  task automatic wait_ready(input int i, input int lim, input string nm);
    int n = 0;
    while (!req_ready[i] && n < lim) begin
      mem_ready = mem_valid;
      tick();
      n++;
    end
    mem_ready = 1'b0;
    cmp(nm, req_ready[i], 1'b1);
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  rv, rwe;
    logic        mr;
    logic [1:0]  ir;
    logic        mv;
    logic [1:0]  rr, iv;
    logic [31:0] ia;
    logic        a5;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [1:0] rv, input logic [1:0] rwe,
                             input logic mr, input logic [1:0] ir, input logic mv,
                             input logic [1:0] rr, input logic [1:0] iv,
                             input logic [31:0] ia, input logic a5);
    vec_t t;
    t.rst = r; t.rv = rv; t.rwe = rwe; t.mr = mr; t.ir = ir;
    t.mv = mv; t.rr = rr; t.iv = iv; t.ia = ia; t.a5 = a5;
    return t;
  endfunction

  initial begin
    vec_t tbl[21];
    logic [127:0] a5 = {16{8'hA5}};
    logic [1:0] pq = 2'b00;
    int done = 0;
    int g[$];
    int n;

    tbl[0]  = v(1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0,    1'b0);
    tbl[1]  = v(1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,    1'b0);
    tbl[2]  = v(1'b0, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 32'h0,    1'b1);
    tbl[3]  = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 32'h0,    1'b1);
    tbl[4]  = v(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 32'h0,    1'b0);
    tbl[5]  = v(1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 32'h0,    1'b0);
    tbl[6]  = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 32'h2040, 1'b0);
    tbl[7]  = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 2'b00, 2'b10, 32'h2040, 1'b0);
    tbl[8]  = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 32'h2040, 1'b0);
    tbl[9]  = v(1'b0, 2'b01, 2'b01, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 32'h2040, 1'b0);
    tbl[10] = v(1'b0, 2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00, 32'h2040, 1'b0);
    tbl[11] = v(1'b0, 2'b11, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 32'h1000, 1'b0);
    tbl[12] = v(1'b0, 2'b11, 2'b10, 1'b0, 2'b00, 1'b1, 2'b00, 2'b11, 32'h1000, 1'b0);
    tbl[13] = v(1'b0, 2'b11, 2'b10, 1'b1, 2'b00, 1'b0, 2'b01, 2'b11, 32'h1000, 1'b1);
    tbl[14] = v(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 32'h1000, 1'b0);
    tbl[15] = v(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 32'h1000, 1'b0);
    tbl[16] = v(1'b0, 2'b10, 2'b10, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 32'h1000, 1'b0);
    tbl[17] = v(1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 32'h1000, 1'b0);
    tbl[18] = v(1'b0, 2'b10, 2'b10, 1'b1, 2'b00, 1'b0, 2'b10, 2'b00, 32'h1000, 1'b0);
    tbl[19] = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 2'b11, 32'h2040, 1'b0);
    tbl[20] = v(1'b0, 2'b00, 2'b00, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 32'h2040, 1'b0);

    req_addr  = {32'h2040, 32'h1000};
    req_mask  = 8'hFF;
    req_ce    = 2'b11;
    req_wdata = {{8{16'h1111}}, {8{16'h2222}}};
    mem_rdata = a5;
    mem_ready = 1'b0;
    inv_ready = 2'b00;
    req_valid = 2'b00;
    req_we    = 2'b00;
    rst       = 1'b1;

    for (int r = 0; r < 21; r++) begin
      rst = tbl[r].rst; req_valid = tbl[r].rv; req_we = tbl[r].rwe;
      mem_ready = tbl[r].mr; inv_ready = tbl[r].ir;
      tick();
      cmp($sformatf("tbl%0d_mem_valid", r), mem_valid, tbl[r].mv);
      cmp($sformatf("tbl%0d_req_ready", r), req_ready, tbl[r].rr);
      cmp($sformatf("tbl%0d_inv_valid", r), inv_valid, tbl[r].iv);
      cmp($sformatf("tbl%0d_inv_addr", r), inv_addr, tbl[r].ia);
      if (tbl[r].a5) cmp($sformatf("tbl%0d_rdata", r), req_rdata, a5);
    end
    mem_ready = 1'b0; inv_ready = 2'b00;

    // Refill from cache 0 completes while its own invalidation is still outstanding.
    req_valid = 2'b10; req_we = 2'b10;
    wait_ready(1, 20, "dl_write_done");
    req_valid = 2'b00; req_we = 2'b00;
    tick();
    cmp("dl_pend_set", inv_valid, 2'b11);
    req_valid = 2'b01; inv_ready = 2'b10;
    n = 0;
    while (!req_ready[0] && n < 50) begin
      mem_ready = mem_valid && (n >= 4);
      tick();
      inv_ready = 2'b00;
      n++;
    end
    mem_ready = 1'b0;
    cmp("dl_refill_done", req_ready[0], 1'b1);
    cmp("dl_pend0_still", inv_valid, 2'b01);
    req_valid = 2'b00; inv_ready = 2'b01;
    tick();
    inv_ready = 2'b00;
    tick();
    cmp("dl_ack_cleared", inv_valid, 2'b00);

    // Grant order with both caches reading continuously, from a fresh pointer.
    rst = 1'b1; tick(); rst = 1'b0;
    req_valid = 2'b11; req_we = 2'b00; mem_ready = 1'b1;
    n = 0;
    while (g.size() < 4 && n < 40) begin
      tick();
      if (req_ready != 2'b00) g.push_back(int'(req_ready == 2'b10));
      n++;
    end
    req_valid = 2'b00; mem_ready = 1'b0;
    cmp("arb_grant_count", g.size(), 4);
    for (int i = 0; i < g.size(); i++) begin
`ifdef ARB_RR_EN
      cmp($sformatf("arb_order%0d", i), g[i], i % 2);
`else
      cmp($sformatf("arb_order%0d", i), g[i], 0);
`endif
    end
    tick();

    // Reset during ISSUE with only cache 0's invalidation left.
    req_valid = 2'b01; req_we = 2'b01;
    wait_ready(0, 20, "rst_write_done");
    req_valid = 2'b00; req_we = 2'b00;
    tick();
    inv_ready = 2'b10;
    tick();
    inv_ready = 2'b00;
    req_valid = 2'b01;
    tick();
    cmp("rst_pre_issue", mem_valid, 1'b1);
    cmp("rst_pre_pend", inv_valid, 2'b01);
    rst = 1'b1;
    tick();
    cmp("rst_mem_valid", mem_valid, 1'b0);
    cmp("rst_inv_valid", inv_valid, 2'b00);
    cmp("rst_req_ready", req_ready, 2'b00);
    rst = 1'b0; req_valid = 2'b00;
    tick();
    cmp("rst_idle_after", mem_valid, 1'b0);

    // Random traffic: requesters hold requests until their completion pulse.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) begin
          pq[i] = 1'b0;
          done++;
        end
        if (!pq[i] && $urandom_range(0, 2) == 0) begin
          pq[i] = 1'b1;
          req_we[i] = ($urandom_range(0, 2) == 0);
          req_ce[i] = 1'($urandom);
          req_addr[i*32 +: 32] = $urandom & 32'hFFFF_FFF0;
          req_mask[i*4 +: 4] = 4'($urandom);
          req_wdata[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      req_valid = pq;
      mem_ready = mem_valid && ($urandom_range(0, 1) == 1);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < NREQ; i++) inv_ready[i] = ($urandom_range(0, 3) == 0);
      tick();
    end
    cmp("rand_progress", done >= 50, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
